temporal_mem_bank: RTL

TEMPORAL_MEM_BANK -- requirements
Module: temporal_mem_bank

---
 rtl/temporal_pkg.sv | 15 +
 rtl/temporal_cell.sv | 108 ++++++++++
 rtl/temporal_mem_bank.sv | 47 ++++
 3 files changed

// File: rtl/temporal_pkg.sv
// Shared definitions for the temporal memory bank.
//   state_e     : per-channel read FSM state (IDLE, READ)
//   CH_DEFAULT  : default number of channels
//   MAX_DEFAULT : default per-channel saturation count
package temporal_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  localparam int unsigned CH_DEFAULT  = 4;
  localparam int unsigned MAX_DEFAULT = 59;

endpackage

// File: rtl/temporal_cell.sv
// One temporal storage channel: accumulates write cycles into a saturating
// count and replays the count as an output pulse of equal length on request.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   we        : add one unit of stored time per sampled-high cycle (IDLE only)
//   re        : rising edge starts a read (IDLE only)
//   q         : output pulse, high for exactly count cycles
//   sat       : count == MAX
//   busy      : read in progress
//   rd_done   : one-cycle strobe at end of read
//   cnt_o     : registered stored count
module temporal_cell
  import temporal_pkg::*;
#(
  parameter int unsigned MAX         = MAX_DEFAULT,
  parameter int unsigned W           = $clog2(MAX + 1),
  parameter bit          DESTRUCTIVE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         re,
  output logic         q,
  output logic         sat,
  output logic         busy,
  output logic         rd_done,
  output logic [W-1:0] cnt_o
);

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   rcnt_q, rcnt_d;
  logic           q_q, q_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  // Set only once re has been sampled low since reset, so a re held high
  // through reset never looks like a fresh rising edge.
  logic           armed_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rcnt_d  = rcnt_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (re && armed_q) begin
          // Read wins over a simultaneous write.
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
            busy_d  = 1'b1;
            q_d     = 1'b1;
            rcnt_d  = count_q;
          end
        end else if (we && (count_q != W'(MAX))) begin
          count_d = count_q + W'(1);
        end
      end
      READ: begin
        // rcnt holds the cycles of q still owed including the current one.
        if (rcnt_q <= W'(1)) begin
          state_d = IDLE;
          q_d     = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rcnt_d  = '0;
          if (DESTRUCTIVE) begin
            count_d = '0;
          end
        end else begin
          rcnt_d = rcnt_q - W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rcnt_q  <= '0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rcnt_q  <= rcnt_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= ~re;
    end
  end

  assign q       = q_q;
  assign busy    = busy_q;
  assign rd_done = done_q;
  assign cnt_o   = count_q;
  assign sat     = (count_q == W'(MAX));

endmodule

// File: rtl/temporal_mem_bank.sv
// Bank of CH independent temporal storage channels.
// Ports (bit k belongs to channel k):
//   clk, rst  : clock, asynchronous active-high reset
//   we, re    : per-channel write enable / read request
//   q         : per-channel output pulse
//   sat       : per-channel saturation flag
//   busy      : per-channel read-in-progress
//   rd_done   : per-channel read-complete strobe
//   cnt_o     : flattened counts, channel k at [k*W +: W]
module temporal_mem_bank
  import temporal_pkg::*;
#(
  parameter int unsigned CH          = CH_DEFAULT,
  parameter int unsigned MAX         = MAX_DEFAULT,
  parameter int unsigned W           = $clog2(MAX + 1),
  parameter bit          DESTRUCTIVE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   we,
  input  logic [CH-1:0]   re,
  output logic [CH-1:0]   q,
  output logic [CH-1:0]   sat,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   rd_done,
  output logic [CH*W-1:0] cnt_o
);

  for (genvar k = 0; k < CH; k++) begin : g_cell
    temporal_cell #(
      .MAX         (MAX),
      .W           (W),
      .DESTRUCTIVE (DESTRUCTIVE)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .we      (we[k]),
      .re      (re[k]),
      .q       (q[k]),
      .sat     (sat[k]),
      .busy    (busy[k]),
      .rd_done (rd_done[k]),
      .cnt_o   (cnt_o[k*W +: W])
    );
  end

endmodule
